// File: rtl/mux_32_8.sv
// Word-to-byte serializer: a small word FIFO feeds an MSB-first 4-byte shifter.
// An idle shifter takes the incoming word directly when the FIFO is empty.
module mux_32_8 #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic        clk_4f,
   input  logic        reset,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ZERO_C  = (ADDR_W+1)'(32'd0);
   localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(32'd1);
   localparam logic [ADDR_W-1:0] P_ONE_C = ADDR_W'(32'd1);

   state_t            state_r, state_s;
   logic [1:0]        cnt_r, cnt_s;
   logic [31:0]       word_r, word_s;
   logic [7:0]        data_out_r, data_s;
   logic              valid_out_r, valid_s;
   logic              fifo_full_r, fifo_empty_r, overflow_r;
   logic [31:0]       mem_r [DEPTH];
   logic [ADDR_W-1:0] rd_ptr_r, wr_ptr_r;
   logic [ADDR_W:0]   count_r, count_s;
   logic              load_s, pop_s, bypass_s, push_s, wr_en_s, drop_s;

   assign data_out   = data_out_r;
   assign valid_out  = valid_out_r;
   assign fifo_full  = fifo_full_r;
   assign fifo_empty = fifo_empty_r;
   assign overflow   = overflow_r;

   // FIFO/shifter handshake: decide pop, bypass, write and drop for this edge
   always_comb begin
      load_s   = (state_r == IDLE) || (cnt_r == 2'd0);
      pop_s    = load_s && (count_r != ZERO_C);
      bypass_s = load_s && (count_r == ZERO_C) && valid_in;
      push_s   = valid_in && !bypass_s;
      wr_en_s  = push_s && ((count_r != FULL_C) || pop_s);
      drop_s   = push_s && !wr_en_s;
      case ({wr_en_s, pop_s})
         2'b10:   count_s = count_r + ONE_C;
         2'b01:   count_s = count_r - ONE_C;
         default: count_s = count_r;
      endcase
   end

   // Serializer next state and next output byte
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      word_s  = word_r;
      data_s  = data_out_r;
      valid_s = valid_out_r;
      if (load_s) begin
         if (pop_s) begin
            word_s = mem_r[rd_ptr_r];
         end else if (bypass_s) begin
            word_s = data_in;
         end else begin
            word_s = word_r;
         end
         if (pop_s || bypass_s) begin
            state_s = SHIFT;
            cnt_s   = 2'd3;
            data_s  = word_s[31:24];
            valid_s = 1'b1;
         end else begin
            state_s = IDLE;
            cnt_s   = 2'd0;
            data_s  = 8'h00;
            valid_s = 1'b0;
         end
      end else begin
         case (cnt_r)
            2'd3:    data_s = word_r[23:16];
            2'd2:    data_s = word_r[15:8];
            2'd1:    data_s = word_r[7:0];
            default: data_s = 8'h00;
         endcase
         state_s = SHIFT;
         cnt_s   = cnt_r - 2'd1;
         valid_s = 1'b1;
      end
   end

   // Serializer registers and output byte
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         cnt_r       <= 2'd0;
         word_r      <= 32'h0000_0000;
         data_out_r  <= 8'h00;
         valid_out_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         word_r      <= word_s;
         data_out_r  <= data_s;
         valid_out_r <= valid_s;
      end
   end

   // FIFO storage, pointers, occupancy, flags and sticky overflow
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
         rd_ptr_r     <= '0;
         wr_ptr_r     <= '0;
         count_r      <= ZERO_C;
         fifo_full_r  <= 1'b0;
         fifo_empty_r <= 1'b1;
         overflow_r   <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= data_in;
            wr_ptr_r        <= wr_ptr_r + P_ONE_C;
         end else begin
            wr_ptr_r        <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + P_ONE_C;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r      <= count_s;
         fifo_full_r  <= (count_s == FULL_C);
         fifo_empty_r <= (count_s == ZERO_C);
         overflow_r   <= overflow_r | drop_s;
      end
   end

endmodule

// File: tb/tb_mux_32_8.sv
// Randomized scoreboard bench for mux_32_8: a queue-based reference decides which
// words are accepted and queues their bytes; a negedge monitor checks the DUT stream.
module tb_mux_32_8;

   localparam int DEPTH = 4;

   logic        clk_4f;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        fifo_full;
   logic        fifo_empty;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   // reference state: accepted-but-unstarted words, bytes left in current word
   logic [31:0] m_q[$];
   logic [7:0]  exp_q[$];
   int          m_rem = 0;
   bit          m_valid = 1'b0;
   bit          m_ovf = 1'b0;

   mux_32_8 #(.DEPTH(DEPTH), .ADDR_W(2)) dut (
      .clk_4f    (clk_4f),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .fifo_full (fifo_full),
      .fifo_empty(fifo_empty),
      .overflow  (overflow)
   );

   initial begin
      clk_4f = 1'b0;
      forever #5 clk_4f = ~clk_4f;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic accept(input logic [31:0] d);
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
   endtask

   // one clock edge of the reference: start a word when the previous one is done
   task automatic model_edge(input logic v, input logic [31:0] d);
      bit consumed = 1'b0;
      bit started  = 1'b0;
      logic [31:0] w;
      if (m_rem == 0) begin
         if (m_q.size() > 0) begin
            w = m_q.pop_front();
            started = 1'b1;
         end else if (v) begin
            consumed = 1'b1;
            started  = 1'b1;
            accept(d);
         end
         m_valid = started;
         m_rem   = started ? 3 : 0;
      end else begin
         m_rem--;
         m_valid = 1'b1;
      end
      if (v && !consumed) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back(d);
            accept(d);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_rem   = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic step(input logic v, input logic [31:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk_4f);
      model_edge(v, d);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0);
   endtask

   // asynchronous reset between edges; outputs must clear without a clock
   task automatic do_reset();
      #2;
      reset    = 1'b0;
      valid_in = 1'b1;
      data_in  = 32'hFFFF_FFFF;
      #1;
      model_clear();
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_fifo_empty", 32'(fifo_empty), 32'h1);
      chk("rst_fifo_full", 32'(fifo_full), 32'h0);
      @(posedge clk_4f);
      #1;
      valid_in = 1'b0;
      reset    = 1'b1;
   endtask

   // monitor: compare every presented byte and the flags against the reference
   always @(negedge clk_4f) begin
      if (reset) begin
         chk("valid_out", 32'(valid_out), 32'(m_valid));
         if (valid_out) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL byte_unexpected: got %02h expected no byte at %0t", data_out, $time);
            end else begin
               chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
         end else begin
            chk("idle_data_out", 32'(data_out), 32'h0);
         end
         chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
         chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      data_in  = 32'h0;
      repeat (3) @(posedge clk_4f);
      #1;
      chk("init_data_out", 32'(data_out), 32'h0);
      chk("init_valid_out", 32'(valid_out), 32'h0);
      chk("init_fifo_empty", 32'(fifo_empty), 32'h1);
      chk("init_fifo_full", 32'(fifo_full), 32'h0);
      chk("init_overflow", 32'(overflow), 32'h0);
      reset = 1'b1;

      // single word: first byte visible right after the sampling edge
      step(1'b1, 32'hA1B2_C3D4);
      chk("single_first_byte", 32'(data_out), 32'hA1);
      idle(6);

      // back-to-back pair streams without a gap
      step(1'b1, 32'h1122_3344);
      step(1'b1, 32'h5566_7788);
      idle(9);

      // fill the FIFO, then push on the edge that pops the head
      for (int i = 1; i <= 6; i++) step(1'b1, 32'(i));
      chk("fill_full", 32'(fifo_full), 32'h1);
      idle(2);
      step(1'b1, 32'h0000_0007);
      chk("pushpop_full", 32'(fifo_full), 32'h1);
      chk("pushpop_no_ovf", 32'(overflow), 32'h0);
      idle(30);

      // sustained burst drops words and latches overflow
      do_reset();
      for (int i = 1; i <= 10; i++) step(1'b1, 32'h0000_0100 + 32'(i));
      chk("burst_overflow", 32'(overflow), 32'h1);
      idle(40);
      chk("overflow_sticky", 32'(overflow), 32'h1);

      // reset in the middle of a word discards the remaining bytes
      do_reset();
      step(1'b1, 32'hDEAD_BEEF);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      chk("midword_byte", 32'(data_out), 32'hBE);
      do_reset();
      step(1'b1, 32'h0102_0304);
      idle(6);

      // spaced words: FIFO never fills, output idles between words
      for (int k = 0; k < 3; k++) begin
         step(1'b1, $urandom);
         idle(5);
      end

      // random traffic, light then heavy
      for (int i = 0; i < 300; i++) step($urandom_range(0, 9) < 2, $urandom);
      for (int i = 0; i < 200; i++) step($urandom_range(0, 9) < 5, $urandom);
      idle(40);
      chk("drain_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
